// File: rtl/e_mdu.sv
// -----------------------------------------------------------------------------
// e_mdu : execute-stage multiply/divide unit with HI/LO architectural registers
//
// Operands and opcode are captured at issue. A 4-bit down-counter then models
// the fixed latency. The result is committed to HI/LO on the edge where the
// counter reaches zero. While an operation is in flight, `busy` is high so the
// D-stage stall unit holds further MDU instructions.
//
// Optional feature macro: MDU_MADD_EN
//   defined   : codes 7..10 (MADD/MADDU/MSUB/MSUBU) accumulate into {HI,LO}
//   undefined : codes 7..10 are reserved and ignored
//
// Parameters
//   MULT_CYCLES : busy cycles for MULT/MULTU (and the MADD family), 1..15
//   DIV_CYCLES  : busy cycles for DIV/DIVU, 1..15
//
// Ports
//   clk     in   1   system clock, rising edge
//   reset   in   1   asynchronous, active-high reset
//   start   in   1   one-cycle issue strobe from E stage
//   mdu_op  in   4   0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,
//                    7 MADD,8 MADDU,9 MSUB,10 MSUBU, 11..15 reserved
//   rs_val  in   32  forwarded rs operand
//   rt_val  in   32  forwarded rt operand
//   busy    out  1   operation in flight (to stall unit)
//   hi      out  32  HI register (MFHI)
//   lo      out  32  LO register (MFLO)
//
// FSM states
//   state  | meaning
//   IDLE   | no operation in flight, accepts start, busy=0
//   RUN    | multiply/divide in flight, counter counting down, busy=1
// -----------------------------------------------------------------------------
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  // The counter is loaded with N-1 so that the commit lands on edge k+N.
  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;

  // ---------------------------------------------------------------------------
  // Issue decode
  // ---------------------------------------------------------------------------
  logic is_mul_class;
  logic is_div_class;

  always_comb begin
    is_mul_class = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
`ifdef MDU_MADD_EN
    if ((mdu_op == OP_MADD) || (mdu_op == OP_MADDU) ||
        (mdu_op == OP_MSUB) || (mdu_op == OP_MSUBU))
      is_mul_class = 1'b1;
`endif
    is_div_class = (mdu_op == OP_DIV) || (mdu_op == OP_DIVU);
  end

  // ---------------------------------------------------------------------------
  // Behavioural datapath on the latched operands
  // ---------------------------------------------------------------------------
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  // Low 64 bits of the sign-extended product equal the signed 32x32 product.
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  logic signed [31:0] sa;
  logic signed [31:0] sb;
  logic signed [31:0] q_s;
  logic signed [31:0] r_s;
  logic [31:0]        q_u;
  logic [31:0]        r_u;
  logic               div_zero;
  logic               div_ovf;

  assign sa       = a_q;
  assign sb       = b_q;
  assign div_zero = (b_q == 32'd0);
  // Most-negative / -1 does not fit; pin to the architectural result.
  assign div_ovf  = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);

  always_comb begin
    q_s = '0;
    r_s = '0;
    q_u = '0;
    r_u = '0;
    if (!div_zero) begin
      q_u = a_q / b_q;
      r_u = a_q % b_q;
      if (!div_ovf) begin
        q_s = sa / sb;
        r_s = sa % sb;
      end else begin
        q_s = 32'sh8000_0000;
        r_s = 32'sd0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Commit value selection
  // ---------------------------------------------------------------------------
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_we;

`ifdef MDU_MADD_EN
  logic [63:0] acc;
  assign acc = {hi, lo};
`endif

  always_comb begin
    res_hi = hi;
    res_lo = lo;
    res_we = 1'b0;
    case (op_q)
      OP_MULT: begin
        {res_hi, res_lo} = prod_s;
        res_we = 1'b1;
      end
      OP_MULTU: begin
        {res_hi, res_lo} = prod_u;
        res_we = 1'b1;
      end
      OP_DIV: begin
        res_lo = q_s;
        res_hi = r_s;
        res_we = !div_zero;
      end
      OP_DIVU: begin
        res_lo = q_u;
        res_hi = r_u;
        res_we = !div_zero;
      end
`ifdef MDU_MADD_EN
      OP_MADD: begin
        {res_hi, res_lo} = acc + prod_s;
        res_we = 1'b1;
      end
      OP_MADDU: begin
        {res_hi, res_lo} = acc + prod_u;
        res_we = 1'b1;
      end
      OP_MSUB: begin
        {res_hi, res_lo} = acc - prod_s;
        res_we = 1'b1;
      end
      OP_MSUBU: begin
        {res_hi, res_lo} = acc - prod_u;
        res_we = 1'b1;
      end
`endif
      default: begin
        res_we = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM, HI/LO and operand registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      cnt   <= 4'd0;
      op_q  <= OP_NONE;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (is_mul_class || is_div_class) begin
              a_q   <= rs_val;
              b_q   <= rt_val;
              op_q  <= mdu_op;
              cnt   <= is_div_class ? DIV_LOAD : MULT_LOAD;
              state <= S_RUN;
              busy  <= 1'b1;
            end else if (mdu_op == OP_MTHI) begin
              hi <= rs_val;
            end else if (mdu_op == OP_MTLO) begin
              lo <= rs_val;
            end
          end
        end
        S_RUN: begin
          // start is ignored here, including on the commit edge.
          if (cnt == 4'd0) begin
            if (res_we) begin
              hi <= res_hi;
              lo <= res_lo;
            end
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
module tb_e_mdu;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;
  int sdb   = 0;  // starts observed while busy

  e_mdu dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mdu_op (mdu_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flags issue while busy; the stall unit should never let this happen.
  always @(posedge clk) begin
    if (!reset && start && busy) sdb++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one op, then count busy cycles (bounded) and watch HI/LO stay put.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int cyc, output bit held);
    logic [31:0] h0, l0;
    @(negedge clk);
    start = 1'b1; mdu_op = op; rs_val = a; rt_val = b;
    h0 = hi; l0 = lo;
    @(posedge clk); #1;
    start = 1'b0; mdu_op = 4'd0;
    cyc = 0; held = 1'b1;
    while (busy && cyc < 40) begin
      cyc++;
      if (hi !== h0 || lo !== l0) held = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // Reference model: architectural rules with wide plain arithmetic.
  task automatic ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] h_in, input logic [31:0] l_in,
                        output logic [31:0] h_out, output logic [31:0] l_out, output int cyc);
    longint la, lb, q, r;
    logic [63:0] sp, up, acc;
    la  = longint'($signed(a));
    lb  = longint'($signed(b));
    sp  = 64'(la * lb);
    up  = 64'(longint'({32'd0, a}) * longint'({32'd0, b}));
    acc = {h_in, l_in};
    h_out = h_in; l_out = l_in; cyc = 0;
    case (op)
      4'd1: begin {h_out, l_out} = sp; cyc = 5; end
      4'd2: begin {h_out, l_out} = up; cyc = 5; end
      4'd3: begin
        cyc = 10;
        if (b != 0) begin
          // 64-bit divide; -2^31/-1 = 2^31 wraps to 0x80000000 naturally.
          q = la / lb; r = la - q * lb;
          l_out = q[31:0]; h_out = r[31:0];
        end
      end
      4'd4: begin
        cyc = 10;
        if (b != 0) begin
          q = longint'({32'd0, a}) / longint'({32'd0, b});
          r = longint'({32'd0, a}) - q * longint'({32'd0, b});
          l_out = q[31:0]; h_out = r[31:0];
        end
      end
      4'd5: h_out = a;
      4'd6: l_out = a;
`ifdef MDU_MADD_EN
      4'd7:  begin {h_out, l_out} = acc + sp; cyc = 5; end
      4'd8:  begin {h_out, l_out} = acc + up; cyc = 5; end
      4'd9:  begin {h_out, l_out} = acc - sp; cyc = 5; end
      4'd10: begin {h_out, l_out} = acc - up; cyc = 5; end
`endif
      default: ;
    endcase
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cyc;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int cyc, mcyc, tcyc;
    bit held;
    logic [31:0] mhi, mlo, nhi, nlo, ra, rb;
    int sdb0;
    int ops[13];

    vecs[0] = '{4'd1, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vecs[1] = '{4'd2, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{4'd4, 32'd7, 32'd2, 32'd0, 32'd0, 32'd1, 32'd3, 10};
    vecs[4] = '{4'd3, 32'd55, 32'd0, 32'h12345678, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0, 10};
    vecs[5] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h1, 32'h2, 32'h0, 32'h80000000, 10};
`ifdef MDU_MADD_EN
    vecs[6] = '{4'd8, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 5};
    vecs[7] = '{4'd9, 32'd2, 32'd3, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
`else
    vecs[6] = '{4'd7, 32'd1, 32'd1, 32'h11, 32'h22, 32'h11, 32'h22, 0};
    vecs[7] = '{4'd0, 32'd9, 32'd9, 32'h33, 32'h44, 32'h33, 32'h44, 0};
`endif
    vecs[8] = '{4'd12, 32'd5, 32'd6, 32'h55, 32'h66, 32'h55, 32'h66, 0};

    ops = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 15};

    start = 1'b0; mdu_op = 4'd0; rs_val = '0; rt_val = '0;
    reset = 1'b1;
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    #16 reset = 1'b0;

    // Asynchronous reset in mid-cycle clears HI/LO without a clock edge.
    do_op(4'd5, 32'hDEADBEEF, 32'd0, cyc, held);
    do_op(4'd6, 32'hCAFEF00D, 32'd0, cyc, held);
    check("mt_hilo", {hi, lo}, {32'hDEADBEEF, 32'hCAFEF00D});
    @(posedge clk); #3 reset = 1'b1; #1;
    check("async_reset_busy", {63'd0, busy}, 64'd0);
    check("async_reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk) reset = 1'b0;

    // Vector table.
    for (int i = 0; i < 9; i++) begin
      do_op(4'd5, vecs[i].pre_hi, 32'd0, cyc, held);
      do_op(4'd6, vecs[i].pre_lo, 32'd0, cyc, held);
      do_op(vecs[i].op, vecs[i].rs, vecs[i].rt, cyc, held);
      check($sformatf("vec%0d_busy_cycles", i), 64'(cyc), 64'(vecs[i].cyc));
      check($sformatf("vec%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].exp_hi});
      check($sformatf("vec%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].exp_lo});
      check($sformatf("vec%0d_held_during_run", i), {63'd0, held}, 64'd1);
    end

    // Reset during a DIV at busy cycle 4 aborts it with no later commit.
    do_op(4'd5, 32'd5, 32'd0, cyc, held);
    do_op(4'd6, 32'd6, 32'd0, cyc, held);
    @(negedge clk);
    start = 1'b1; mdu_op = 4'd3; rs_val = 32'd100; rt_val = 32'd7;
    @(posedge clk); #1 start = 1'b0; mdu_op = 4'd0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1; #1;
    check("div_abort_busy", {63'd0, busy}, 64'd0);
    check("div_abort_hilo", {hi, lo}, 64'd0);
    @(negedge clk) reset = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("div_abort_no_commit", {hi, lo}, 64'd0);
    check("div_abort_idle", {63'd0, busy}, 64'd0);

    // MTLO issued during RUN (cycle 2 and on the commit edge) is ignored.
    sdb0 = sdb;
    tcyc = 0;
    @(negedge clk);
    start = 1'b1; mdu_op = 4'd1; rs_val = 32'd3; rt_val = 32'd4;
    @(posedge clk);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      start = 1'b0; mdu_op = 4'd0;
      if (busy) tcyc++;
      if (i == 2 || i == 5) begin
        start = 1'b1; mdu_op = 4'd6; rs_val = 32'hAA;
      end
    end
    check("busy_issue_cycles", 64'(tcyc), 64'd5);
    check("busy_issue_lo", {32'd0, lo}, 64'd12);
    check("busy_issue_hi", {32'd0, hi}, 64'd0);
    check("busy_issue_flagged", 64'(sdb - sdb0), 64'd2);

    // Randomized ops against the reference model.
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    mhi = '0; mlo = '0;
    for (int n = 0; n < 60; n++) begin
      logic [3:0] op;
      op = 4'(ops[$urandom_range(0, 12)]);
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(8, 30);
      ref_op(op, ra, rb, mhi, mlo, nhi, nlo, mcyc);
      do_op(op, ra, rb, cyc, held);
      mhi = nhi; mlo = nlo;
      check($sformatf("rnd%0d_op%0d_cycles", n, op), 64'(cyc), 64'(mcyc));
      check($sformatf("rnd%0d_op%0d_hilo", n, op), {hi, lo}, {mhi, mlo});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit for the pipelined MIPS core.
- It produces the `busy` signal that the D-stage stall unit consumes. The stall unit holds any MDU-class instruction in D while `start` or `busy` is high.
- It holds the HI/LO architectural registers. MFHI/MFLO read them through the `hi`/`lo` outputs.
- Operands are latched at issue, so the pipeline may keep advancing non-MDU instructions while `busy` is high.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for MULT/MULTU (and MADD/MSUB variants); legal range 1..15.
- DIV_CYCLES, 10, number of busy cycles for DIV/DIVU; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  issue strobe from E stage, valid for one cycle per MDU instruction.
- mdu_op  input  4  operation code:
  - 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO
  - 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU (only when the macro is enabled)
  - 11..15 reserved
- rs_val  input  32  forwarded rs operand.
- rt_val  input  32  forwarded rt operand.
- busy  output  1  operation in flight; goes to the stall unit.
- hi  output  32  HI register (drives MFHI).
- lo  output  32  LO register (drives MFLO).

Behaviour:
- Reset: asynchronous and active-high. While `reset` is high: `busy`=0, `hi`=0, `lo`=0, state=IDLE, counter=0.
  - Asserting `reset` mid-operation aborts it. No HI/LO update occurs.
- States:
  - IDLE: `busy`=0.
  - RUN: `busy`=1, a 4-bit down-counter is active.
- IDLE with `start`=1 sampled at edge k:
  - MULT/MULTU/DIV/DIVU (and MADD family when enabled):
    - Latch `rs_val`, `rt_val` and `mdu_op`.
    - Load counter with MULT_CYCLES-1 or DIV_CYCLES-1.
    - Enter RUN. `busy`=1 from after edge k.
  - MTHI: `hi`<=`rs_val` at edge k, stay in IDLE. Same for MTLO with `lo`<=`rs_val`. No `busy`.
  - NONE or a reserved code: ignored.
- RUN:
  - The counter decrements each edge.
  - On the edge where the counter is 0: commit the result to HI/LO, return to IDLE, `busy` drops.
  - Total `busy` duration is exactly N cycles: result visible and `busy`=0 after edge k+N.
  - The HI/LO register values shown at issue stay unchanged during RUN.
- Arithmetic:
  - MULT: signed 32x32 to 64-bit product; HI=prod[63:32], LO=prod[31:0]. MULTU: same, unsigned.
  - DIV: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend. DIVU: unsigned.
  - Divide by zero (latched rt=0): the operation still runs DIV_CYCLES; HI and LO stay unchanged at commit.
  - Signed 0x80000000 / -1: LO=0x80000000, HI=0.
- Start while busy: `start`=1 during RUN is ignored, including MTHI/MTLO. The stall unit guarantees this does not occur. A bench assertion flags it.
- `start`=1 on the same edge that commits: still in RUN, so it is ignored. The stall unit holds the instruction one more cycle.
- The datapath may be behavioural (`*`, `/`, `%`). The delay counter models the latency.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - Codes 7..10 are legal and take MULT_CYCLES.
  - MADD: {HI,LO} <= {HI,LO} + signed product. MADDU: the same with an unsigned product.
  - MSUB/MSUBU: subtract the product instead.
  - The 64-bit accumulate wraps modulo 2^64. The {HI,LO} value used is the one sampled at commit.
- Not defined: codes 7..10 are treated as reserved and ignored with no `busy`. The accumulate logic is absent.

Test Plan:
- Reset:
  - Pulse `reset` asynchronously mid-cycle → `busy`=0, `hi`=0, `lo`=0 immediately.
  - Start DIV, assert `reset` at busy cycle 4 → `busy`=0 at once, HI/LO=0, no later commit.
- MULT:
  - `rs`=0xFFFFFFFF (-1), `rt`=0x00000002, `start` at edge k → `busy` high for exactly 5 cycles.
  - After edge k+5: HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIV:
  - `rs`=-7 (0xFFFFFFF9), `rt`=2 → after 10 busy cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
  - DIVU 7/2 → LO=3, HI=1.
- Divide by zero and overflow:
  - MTHI 0x12345678, MTLO 0x9ABCDEF0, then DIV by rt=0 → `busy` for 10 cycles, HI/LO unchanged.
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Issue during busy:
  - `start` MULT 3x4, then `start` MTLO 0xAA at busy cycle 2 and at the commit edge → both ignored. LO=12, HI=0, `busy` timing unchanged.
- MDU_MADD_EN:
  - With HI=0, LO=0xFFFFFFFF, MADDU 1x1 → HI=1, LO=0.
  - MSUB 2x3 from {0,0} → HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - With the macro undefined, code 7 → `busy` stays 0, HI/LO unchanged.
